// File: rtl/ee310_pkg.sv
// Shared types and constants for the lab datapath button conditioner.
// Holds the debounce FSM state type and the board-rate default.
package ee310_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    // 20 ms at 50 MHz
    localparam int DEBOUNCE_50MHZ_20MS = 1_000_000;

endpackage

// File: rtl/button_conditioner_if.sv
// Signal bundle between a raw push-button source and its conditioner.
// master drives the raw button; slave returns the conditioned view.
interface button_conditioner_if #(
    parameter int COUNT_W = 8
);

    logic               btn_in;
    logic               btn_level;
    logic               btn_press;
    logic               btn_release;
    logic [COUNT_W-1:0] press_count;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  press_count
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output press_count
    );

endinterface

// File: rtl/d_ff.sv
// Single D flip-flop with asynchronous active-low clear.
// Used back-to-back as the button synchronizer.
module d_ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= 1'b0;
        else        q <= d;
    end

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects one raw push-button.
// Outputs a clean level, press/release pulses and a wrapping press count.
module button_conditioner
    import ee310_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS,
    parameter int COUNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic s1;
    logic s_q;

    d_ff u_sync1 (
        .clk   (clk),
        .reset (reset),
        .d     (bus.btn_in),
        .q     (s1)
    );

    d_ff u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (s1),
        .q     (s_q)
    );

    btn_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               rel_q, rel_d;
    logic [COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            count_q <= count_d;
        end
    end

    // Level is held through the wait states so a bounce never disturbs it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        count_d = count_q;
        case (state_q)
            RELEASED: begin
                if (s_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + COUNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = rel_q;
    assign bus.press_count = count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a short debounce window.
// Vector table, hand sequences and random stimulus against a run-length model.
module tb_button_conditioner;
    import ee310_pkg::*;

    localparam int D  = 4;
    localparam int CW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    button_conditioner_if #(.COUNT_W(CW)) bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .COUNT_W         (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: a change is accepted once the synchronized input has disagreed
    // with the accepted level for D+1 consecutive samples.
    logic          m_s1, m_sq, m_level, m_press, m_rel;
    logic [CW-1:0] m_count;
    int            m_run;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1 <= 0; m_sq <= 0; m_level <= 0;
            m_press <= 0; m_rel <= 0; m_count <= 0; m_run <= 0;
        end else begin
            m_s1    <= bus.btn_in;
            m_sq    <= m_s1;
            m_press <= 0;
            m_rel   <= 0;
            if (m_sq != m_level) begin
                if (m_run == D) begin
                    m_level <= m_sq;
                    m_press <= m_sq;
                    m_rel   <= !m_sq;
                    m_run   <= 0;
                    if (m_sq) m_count <= m_count + 1'b1;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    function automatic logic [31:0] outs();
        return {27'd0, bus.btn_level, bus.btn_press, bus.btn_release,
                bus.press_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        bus.btn_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit btn;
        bit lvl;
        bit prs;
        bit rel;
        int cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int npress, nrel, pedge, lvl_low, hold, cap;
        bit b;

        for (int i = 0; i < 16; i++) begin
            tbl[i].btn = (i < 8);
            tbl[i].lvl = (i >= 6 && i < 14);
            tbl[i].prs = (i == 6);
            tbl[i].rel = (i == 14);
            tbl[i].cnt = (i >= 6) ? 1 : 0;
        end

        // Reset held: toggling input has no effect
        reset      = 1'b0;
        bus.btn_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.btn_in = i[0];
            tick();
            check("reset_hold", outs(), 0);
        end

        // Clean press then clean release
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.btn_in = tbl[i].btn;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {27'd0, tbl[i].lvl, tbl[i].prs, tbl[i].rel,
                   CW'(tbl[i].cnt)});
        end

        // Async reset in the middle of PRESS_WAIT
        do_reset();
        bus.btn_in = 1'b1;
        repeat (3) tick();
        check("pw_state", dut.state_q, PRESS_WAIT);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_state", dut.state_q, RELEASED);
        check("async_outs", outs(), 0);
        bus.btn_in = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        npress = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            npress += bus.btn_press;
        end
        check("post_reset_press", npress, 0);

        // Press bounce: high 3, low 1, then held
        do_reset();
        npress = 0;
        pedge  = -1;
        for (int i = 0; i < 16; i++) begin
            bus.btn_in = (i < 3) || (i >= 4);
            tick();
            if (bus.btn_press) begin
                npress++;
                pedge = i;
            end
        end
        check("bounce_npress", npress, 1);
        check("bounce_edge", pedge, 10);
        check("bounce_level", bus.btn_level, 1);

        // Release glitch of two cycles while pressed
        nrel    = 0;
        lvl_low = 0;
        for (int i = 0; i < 12; i++) begin
            bus.btn_in = (i >= 2);
            tick();
            nrel += bus.btn_release;
            if (!bus.btn_level) lvl_low = 1;
        end
        check("glitch_nrel", nrel, 0);
        check("glitch_level", lvl_low, 0);
        check("glitch_count", bus.press_count, 1);

        // Four presses wrap the counter
        do_reset();
        for (int p = 0; p < 4; p++) begin
            npress     = 0;
            cap        = -1;
            bus.btn_in = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (bus.btn_press) begin
                    npress++;
                    cap = bus.press_count;
                end
            end
            bus.btn_in = 1'b0;
            repeat (8) tick();
            check($sformatf("wrap%0d_pulses", p), npress, 1);
            check($sformatf("wrap%0d_count", p), cap, (p + 1) % 4);
        end

        // Random stimulus against the model
        do_reset();
        hold = 0;
        b    = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                b    = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 2 * D + 3);
            end
            hold--;
            bus.btn_in = b;
            tick();
            check("random", outs(),
                  {27'd0, m_level, m_press, m_rel, m_count});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
